// File: rtl/tx_delay_ch_if.sv
// tx_delay_ch_if -- control/status bundle for one transmit-delay channel.
//
// Signals (master = controller side, slave = tx_delay_ch):
//   lut_addr, lut_din, lut_we : focal-zone delay LUT write port
//   zone_sel                  : focal zone, read on the fire edge
//   tx_start                  : single-cycle fire request
//   tx_abort                  : abort current firing
//   ch_en                     : apodization mask, 0 = silent channel
//   half_per, num_cyc         : pulse shape, sampled on the fire edge
//   pulse_p, pulse_n          : registered pulser drives
//   tx_busy, tx_done          : firing in progress / one-cycle completion
//   fsm_state                 : current FSM state encoding, for observation
//
// Handshake: there is no valid/ready pair. tx_start and tx_abort are
// single-cycle strobes sampled on every rising clk edge; tx_start is only
// honoured while the channel is idle (tx_busy=0) and is never queued, and
// tx_abort wins over tx_start when both are high on the same edge.
interface tx_delay_ch_if #(
  parameter int ADDR_WD = 6,
  parameter int DLY_WD  = 12,
  parameter int HALF_WD = 8,
  parameter int CYC_WD  = 4
);
  logic [ADDR_WD-1:0] lut_addr;
  logic [DLY_WD-1:0]  lut_din;
  logic               lut_we;
  logic [ADDR_WD-1:0] zone_sel;
  logic               tx_start;
  logic               tx_abort;
  logic               ch_en;
  logic [HALF_WD-1:0] half_per;
  logic [CYC_WD-1:0]  num_cyc;
  logic               pulse_p;
  logic               pulse_n;
  logic               tx_busy;
  logic               tx_done;
  logic [2:0]         fsm_state;

  modport master (
    output lut_addr, lut_din, lut_we, zone_sel, tx_start, tx_abort,
           ch_en, half_per, num_cyc,
    input  pulse_p, pulse_n, tx_busy, tx_done, fsm_state
  );

  modport slave (
    input  lut_addr, lut_din, lut_we, zone_sel, tx_start, tx_abort,
           ch_en, half_per, num_cyc,
    output pulse_p, pulse_n, tx_busy, tx_done, fsm_state
  );
endinterface

// File: rtl/tx_delay_ch.sv
// tx_delay_ch -- one ultrasound transmit channel: per-focal-zone delay LUT
// followed by a bipolar pulse burst generator.
//
// Ports:
//   clk  : single clock, all logic on its rising edge
//   rst  : synchronous active-high reset (LUT contents are kept)
//   bus  : tx_delay_ch_if.slave (LUT write port, fire control, pulse outputs,
//          busy/done status and FSM state for observation)
//
// Timing with tx_start sampled at edge k, D = LUT[zone], H = half period,
// N = cycle count: busy from k+1, first pulse_p at k+2+D, tx_done at
// k+2+D+2*H*N (edges counted as the value visible at that edge).
module tx_delay_ch #(
  parameter int ADDR_WD = 6,
  parameter int DLY_WD  = 12,
  parameter int HALF_WD = 8,
  parameter int CYC_WD  = 4
) (
  input logic         clk,
  input logic         rst,
  tx_delay_ch_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DELAY = 3'd2,
    S_POS   = 3'd3,
    S_NEG   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state;
  logic [DLY_WD-1:0]  mem [2**ADDR_WD];
  logic [DLY_WD-1:0]  lut_q;
  logic [DLY_WD-1:0]  dcnt;
  logic [HALF_WD-1:0] h_r;
  logic [HALF_WD-1:0] hcnt;
  logic [CYC_WD-1:0]  n_r;
  logic [CYC_WD-1:0]  ccnt;
  logic               en_r;
  logic               pulse_p;
  logic               pulse_n;
  logic               tx_busy;
  logic               tx_done;

  // Delay LUT. The read is registered from zone_sel every cycle, so the
  // value captured on the fire edge is exactly "zone_sel latched at fire";
  // a write on that same edge is not yet visible (old data is returned).
  // No reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (bus.lut_we) mem[bus.lut_addr] <= bus.lut_din;
    lut_q <= mem[bus.zone_sel];
  end

  // Counters count down to 1 and transition there rather than at 0, so
  // the full range (D = 2^DLY_WD-1, N = 2^CYC_WD-1) never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pulse_p <= 1'b0;
      pulse_n <= 1'b0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      dcnt    <= '0;
      hcnt    <= '0;
      ccnt    <= '0;
      h_r     <= '0;
      n_r     <= '0;
      en_r    <= 1'b0;
    end else if (state != S_IDLE && bus.tx_abort) begin
      state   <= S_IDLE;
      pulse_p <= 1'b0;
      pulse_n <= 1'b0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          pulse_p <= 1'b0;
          pulse_n <= 1'b0;
          tx_done <= 1'b0;
          tx_busy <= 1'b0;
          if (bus.tx_start && !bus.tx_abort) begin
            // half_per=0 behaves as a one-clock half period
            h_r     <= (bus.half_per == '0) ? HALF_WD'(1) : bus.half_per;
            n_r     <= bus.num_cyc;
            en_r    <= bus.ch_en;
            tx_busy <= 1'b1;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (lut_q == '0) begin
            if (n_r == '0) begin
              state   <= S_DONE;
              tx_done <= 1'b1;
            end else begin
              state   <= S_POS;
              hcnt    <= h_r;
              ccnt    <= n_r;
              pulse_p <= en_r;
            end
          end else begin
            dcnt  <= lut_q;
            state <= S_DELAY;
          end
        end
        S_DELAY: begin
          if (dcnt == DLY_WD'(1)) begin
            if (n_r == '0) begin
              state   <= S_DONE;
              tx_done <= 1'b1;
            end else begin
              state   <= S_POS;
              hcnt    <= h_r;
              ccnt    <= n_r;
              pulse_p <= en_r;
            end
          end else begin
            dcnt <= dcnt - DLY_WD'(1);
          end
        end
        S_POS: begin
          if (hcnt == HALF_WD'(1)) begin
            state   <= S_NEG;
            hcnt    <= h_r;
            pulse_p <= 1'b0;
            pulse_n <= en_r;
          end else begin
            hcnt <= hcnt - HALF_WD'(1);
          end
        end
        S_NEG: begin
          if (hcnt == HALF_WD'(1)) begin
            pulse_n <= 1'b0;
            if (ccnt == CYC_WD'(1)) begin
              state   <= S_DONE;
              tx_done <= 1'b1;
            end else begin
              state   <= S_POS;
              ccnt    <= ccnt - CYC_WD'(1);
              hcnt    <= h_r;
              pulse_p <= en_r;
            end
          end else begin
            hcnt <= hcnt - HALF_WD'(1);
          end
        end
        S_DONE: begin
          tx_done <= 1'b0;
          tx_busy <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          pulse_p <= 1'b0;
          pulse_n <= 1'b0;
          tx_busy <= 1'b0;
          tx_done <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pulse_p   = pulse_p;
  assign bus.pulse_n   = pulse_n;
  assign bus.tx_busy   = tx_busy;
  assign bus.tx_done   = tx_done;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_tx_delay_ch.sv
// tb_tx_delay_ch -- directed bench for tx_delay_ch. Each firing is compared
// edge by edge against a closed-form timing model of the channel outputs.
module tb_tx_delay_ch;
  localparam int ADDR_WD = 6;
  localparam int DLY_WD  = 12;
  localparam int HALF_WD = 8;
  localparam int CYC_WD  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tx_delay_ch_if #(.ADDR_WD(ADDR_WD), .DLY_WD(DLY_WD),
                   .HALF_WD(HALF_WD), .CYC_WD(CYC_WD)) bus ();

  tx_delay_ch #(.ADDR_WD(ADDR_WD), .DLY_WD(DLY_WD),
                .HALF_WD(HALF_WD), .CYC_WD(CYC_WD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected {pulse_p, pulse_n, tx_busy, tx_done} as seen at edge e
  // (fire sampled at edge 0); everything is zero after an abort/reset edge.
  function automatic logic [3:0] model(input int d, input int h, input int n,
                                       input int en, input int e,
                                       input int abort_at);
    int   heff;
    int   t_end;
    int   ph;
    logic p, nn, busy, done;
    heff  = (h == 0) ? 1 : h;
    t_end = 2 + d + 2 * heff * n;
    p = 1'b0; nn = 1'b0;
    busy = (e >= 1) && (e <= t_end);
    done = (e == t_end);
    if (n > 0 && e >= 2 + d && e < t_end) begin
      ph = (e - 2 - d) / heff;
      p  = (en != 0) && (ph % 2 == 0);
      nn = (en != 0) && (ph % 2 == 1);
    end
    if (abort_at > 0 && e > abort_at) return 4'b0000;
    return {p, nn, busy, done};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_lut(input int addr, input int val);
    bus.lut_we   = 1'b1;
    bus.lut_addr = ADDR_WD'(addr);
    bus.lut_din  = DLY_WD'(val);
    step();
    bus.lut_we   = 1'b0;
  endtask

  // Fire on the next edge (edge 0) and check every following edge.
  // abort_at: edge on which tx_abort (or rst if use_rst) is applied.
  // restart_at: edge on which a stray tx_start is applied.
  // max_e: last edge to observe (0 = one edge past tx_done).
  task automatic run_fire(input string name, input int zone, input int d,
                          input int h, input int n, input int en,
                          input int abort_at, input int use_rst,
                          input int restart_at, input int max_e,
                          input int wr_on_fire, input int wr_val);
    int last;
    logic [3:0] obs;
    last = (max_e > 0) ? max_e : 3 + d + 2 * ((h == 0) ? 1 : h) * n;
    bus.zone_sel = ADDR_WD'(zone);
    bus.half_per = HALF_WD'(h);
    bus.num_cyc  = CYC_WD'(n);
    bus.ch_en    = en[0];
    bus.tx_start = 1'b1;
    if (wr_on_fire != 0) begin
      bus.lut_we   = 1'b1;
      bus.lut_addr = ADDR_WD'(zone);
      bus.lut_din  = DLY_WD'(wr_val);
    end
    step();
    // scramble fire-time inputs: the channel must use latched values
    bus.tx_start = 1'b0;
    bus.lut_we   = 1'b0;
    bus.zone_sel = ADDR_WD'($urandom_range(0, 63));
    bus.half_per = HALF_WD'($urandom_range(0, 255));
    bus.num_cyc  = CYC_WD'($urandom_range(0, 15));
    bus.ch_en    = 1'(~en[0]);
    for (int e = 1; e <= last; e++) begin
      obs = {bus.pulse_p, bus.pulse_n, bus.tx_busy, bus.tx_done};
      check_eq($sformatf("%s e%0d", name, e), {28'd0, obs},
               {28'd0, model(d, h, n, en, e, abort_at)});
      if (e == last) break;
      bus.tx_abort = (e == abort_at) && (use_rst == 0);
      rst          = (e == abort_at) && (use_rst != 0);
      bus.tx_start = (e == restart_at);
      step();
      bus.tx_abort = 1'b0;
      rst          = 1'b0;
      bus.tx_start = 1'b0;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst          = 1'b1;
    bus.lut_addr = '0;
    bus.lut_din  = '0;
    bus.lut_we   = 1'b0;
    bus.zone_sel = '0;
    bus.tx_start = 1'b0;
    bus.tx_abort = 1'b0;
    bus.ch_en    = 1'b0;
    bus.half_per = '0;
    bus.num_cyc  = '0;
    step();
    step();
    check_eq("reset outs", {28'd0, bus.pulse_p, bus.pulse_n, bus.tx_busy,
             bus.tx_done}, 32'd0);
    check_eq("reset state", {29'd0, bus.fsm_state}, 32'd0);
    rst = 1'b0;
    step();

    write_lut(3, 10);
    write_lut(0, 0);
    write_lut(7, 3);
    write_lut(5, 4095);
    write_lut(9, 1);
    step();

    run_fire("basic",      3, 10, 4, 2, 1, 0, 0, 0, 0, 0, 0);
    run_fire("d0_h0",      0, 0,  0, 1, 1, 0, 0, 0, 0, 0, 0);
    run_fire("silent",     3, 10, 4, 2, 0, 0, 0, 0, 0, 0, 0);
    run_fire("abort",      3, 10, 4, 2, 1, 14, 0, 0, 15, 0, 0);
    run_fire("after_abrt", 3, 10, 4, 2, 1, 0, 0, 0, 0, 0, 0);
    run_fire("restart",    3, 10, 4, 2, 1, 0, 0, 5, 0, 0, 0);
    run_fire("wr_on_fire", 3, 10, 4, 2, 1, 0, 0, 0, 0, 1, 20);
    run_fire("new_delay",  3, 20, 4, 2, 1, 0, 0, 0, 0, 0, 0);
    run_fire("n0",         7, 3,  2, 0, 1, 0, 0, 0, 0, 0, 0);
    run_fire("d0_n0",      0, 0,  3, 0, 1, 0, 0, 0, 0, 0, 0);
    run_fire("n_max",      9, 1,  1, 15, 1, 0, 0, 0, 0, 0, 0);
    run_fire("h_max",      0, 0,  255, 1, 1, 0, 0, 0, 0, 0, 0);
    run_fire("d_max",      5, 4095, 2, 1, 1, 0, 0, 0, 0, 0, 0);
    run_fire("rst_mid",    3, 20, 4, 2, 1, 8, 1, 0, 9, 0, 0);
    check_eq("rst_mid state", {29'd0, bus.fsm_state}, 32'd0);
    run_fire("after_rst",  9, 1,  3, 2, 1, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tx_delay_ch.md
TX_DELAY_CH -- requirements
Module: tx_delay_ch

Interface
REQ-001 SHALL have parameter ADDR_WD, default 6, focal-zone LUT address width (depth 2^ADDR_WD).
REQ-002 SHALL have parameter DLY_WD, default 12, transmit delay width in clk cycles.
REQ-003 SHALL have parameter HALF_WD, default 8, pulse half-period width.
REQ-004 SHALL have parameter CYC_WD, default 4, pulse cycle-count width.
REQ-005 SHALL have port clk  input  1  the only clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port lut_addr  input  ADDR_WD  delay LUT write address.
REQ-008 SHALL have port lut_din  input  DLY_WD  delay LUT write data.
REQ-009 SHALL have port lut_we  input  1  LUT write enable.
REQ-010 SHALL have port zone_sel  input  ADDR_WD  focal zone read at fire.
REQ-011 SHALL have port tx_start  input  1  fire request, single-cycle pulse.
REQ-012 SHALL have port tx_abort  input  1  abort current firing.
REQ-013 SHALL have port ch_en  input  1  channel apodization mask; 0 = silent channel.
REQ-014 SHALL have port half_per  input  HALF_WD  half-period in clks, sampled at fire.
REQ-015 SHALL have port num_cyc  input  CYC_WD  pulse cycles, sampled at fire.
REQ-016 SHALL have port pulse_p  output  1  positive pulser drive, registered.
REQ-017 SHALL have port pulse_n  output  1  negative pulser drive, registered.
REQ-018 SHALL have port tx_busy  output  1  firing in progress.
REQ-019 SHALL have port tx_done  output  1  one-cycle completion strobe.

Function
REQ-020 SHALL store lut_din at lut_addr on any edge with lut_we=1, in any state.
REQ-021 SHALL read the LUT synchronously; write and read of the same address on the same edge returns the old data.
REQ-022 SHALL implement states IDLE, LOAD, DELAY, POS, NEG, DONE.
REQ-023 SHALL, in IDLE on an edge with tx_start=1, latch zone_sel, half_per, num_cyc and ch_en, and go to LOAD.
REQ-024 SHALL, in LOAD, load the delay counter with LUT[zone] (D), then go to DELAY.
REQ-025 SHALL count D clocks in DELAY, then enter POS; D=0 enters POS directly with no DELAY cycle.
REQ-026 SHALL hold POS for H clocks, then NEG for H clocks, and repeat the pair N times; H = latched half_per, and half_per=0 is treated as H=1.
REQ-027 SHALL make the timing exact: with tx_start sampled at edge k, pulse_p rises at edge k+2+D, and tx_done rises at edge k+2+D+2*H*N.
REQ-028 SHALL drive pulse_p=1 only in POS and pulse_n=1 only in NEG, each only when latched ch_en=1; both SHALL never be 1 together.
REQ-029 SHALL, when latched ch_en=0, run identical timing with both pulse outputs held 0.
REQ-030 SHALL, when num_cyc=0, skip POS/NEG and go from DELAY (or LOAD if D=0) to DONE.
REQ-031 SHALL spend one cycle in DONE with tx_done=1, then return to IDLE.
REQ-032 SHALL hold tx_busy=1 from edge k+1 through the DONE cycle inclusive, and 0 in IDLE.
REQ-033 SHALL ignore tx_start when not in IDLE, with no queuing.
REQ-034 SHALL, on tx_abort=1 in any non-IDLE state, go to IDLE at that edge with pulse_p, pulse_n, tx_busy and tx_done all 0, and without asserting tx_done.
REQ-035 SHALL give tx_abort priority over tx_start on the same edge.
REQ-036 SHALL use modulo-free counters: the delay counter SHALL not wrap at D = 2^DLY_WD-1, and the cycle counter SHALL not wrap at N = 2^CYC_WD-1.

Reset
REQ-037 SHALL, with rst=1 at an edge, set state IDLE and set pulse_p, pulse_n, tx_busy and tx_done to 0, overriding all other inputs.
REQ-038 SHALL, on reset mid-firing, abort the firing the same way as tx_abort.
REQ-039 SHALL not clear the LUT contents on reset; LUT contents are undefined until written.

Verification
REQ-040 SHALL verify: write LUT[3]=10; fire with zone_sel=3, half_per=4, num_cyc=2, ch_en=1 at edge 0 -> pulse_p high at edges 12-15 and 20-23, pulse_n high at edges 16-19 and 24-27, tx_done at edge 28 only.
REQ-041 SHALL verify: LUT[0]=0, half_per=0, num_cyc=1 -> pulse_p at edge 2, pulse_n at edge 3, tx_done at edge 4.
REQ-042 SHALL verify: ch_en=0 with the REQ-040 setup -> pulses stay 0, tx_busy over edges 1-28, tx_done at edge 28.
REQ-043 SHALL verify: tx_abort at edge 14 of the REQ-040 case -> all outputs 0 from edge 14, no tx_done; a new tx_start at edge 15 fires normally.
REQ-044 SHALL verify: tx_start repeated at edge 5 during busy -> ignored, and timing is identical to REQ-040.
REQ-045 SHALL verify: lut_we to LUT[3]=20 on the fire edge -> the firing uses 10; the next firing uses 20.
